imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Byte-stream program loader and write-side initiator of the instruction memory.
//  Accepts a framed byte stream from the serial receiver: length, payload, checksum.
//  Assembles little-endian 32-bit words and writes each to consecutive word indices.
//  Holds the CPU (cpu_hold) while a load is in progress.
// PARAMETERS
//  DEPTH        128        instruction memory depth in words
//  ADDR_W       7          word-index width, $clog2(DEPTH)
//  TIMEOUT_CYC  1_000_000  max idle cycles between bytes before abort
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       one-cycle pulse: arm a new load
//  rx_valid     in   1       rx_data holds a new byte this cycle; at most one byte per cycle
//  rx_data      in   8       received byte
//  mem_we       out  1       one-cycle write strobe to the instruction memory write port
//  mem_addr     out  ADDR_W  word index for the write
//  mem_wdata    out  32      word to write
//  cpu_hold     out  1       high while busy; keeps CPU in reset
//  done         out  1       sticky: load completed, checksum good
//  error        out  1       sticky: bad length, bad checksum or timeout
//  words_loaded out  ADDR_W+1  count of words written in the current/last load
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; internal word/byte/timeout counters 0.
//  States: IDLE -> LEN -> DATA -> CSUM -> DONE | ERR.
//   IDLE: rx_valid ignored. start -> LEN; clears done, error, words_loaded, checksum.
//   LEN : first byte N = word count. 1<=N<=DEPTH -> DATA; N==0 or N>DEPTH -> ERR.
//   DATA: byte k of a word goes to bits [8k+7:8k], k=0 first.
//         When the 4th byte is accepted, in the next cycle: mem_we=1 for 1 cycle,
//         mem_addr = word index (0-based), mem_wdata = assembled word.
//         words_loaded increments in that same cycle.
//         After the N-th word's 4th byte -> CSUM.
//         Back-to-back bytes are accepted every cycle, including the write cycle.
//   CSUM: next byte compared with the XOR of all 4N payload bytes. The length byte is excluded.
//         Equal -> DONE; else -> ERR.
//   DONE/ERR: done or error held high until the next start. start -> LEN as in IDLE.
//  cpu_hold = 1 in LEN, DATA and CSUM; 0 otherwise.
//  Timeout: counter clears on each accepted byte and counts in LEN/DATA/CSUM.
//   Reaching TIMEOUT_CYC -> ERR. A partial word is discarded; no mem_we is issued for it.
//  start while in LEN/DATA/CSUM: ignored.
//  mem_addr never wraps; N<=DEPTH bounds it to DEPTH-1.
//  Words already written before an ERR remain in memory. Only error flags the load bad.
//  rst_n low mid-load: immediate return to IDLE; mem_we drops asynchronously;
//   partially written memory is left as is.
//  mem_addr/mem_wdata hold their last value when mem_we=0.
// STRUCTURE
//  loader_pkg: state enum (IDLE, LEN, DATA, CSUM, DONE, ERR); DEPTH/ADDR_W defaults;
//   frame constants.
//  Sub-module word_assembler: byte lane counter plus 32-bit shift register.
//   Outputs word_valid and word; cleared by the FSM on start and on abort.
//  Top: FSM, word counter, XOR checksum, timeout counter, registered write port.
// TESTING
//  1. N=1, bytes 13 00 00 00, csum 13 -> mem_we once, addr 0, wdata 0x00000013; done=1.
//  2. N=3 back-to-back, 12 bytes, correct XOR -> writes at addr 0,1,2 on consecutive word
//     boundaries; words_loaded=3; cpu_hold falls with done.
//  3. N=2, csum byte wrong (true XOR ^ 0xFF) -> 2 writes occur; error=1, done=0.
//  4. Length byte 0x00, then 0x81 (129) -> ERR immediately, no mem_we.
//  5. N=2, stall after 6 bytes for TIMEOUT_CYC cycles -> error=1; only addr 0 written.
//  6. rst_n pulsed low mid-DATA, then start plus a good N=128 frame -> full write 0..127;
//     done=1; words_loaded=128.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int DEF_DEPTH       = 128;
    localparam int DEF_ADDR_W      = 7;
    localparam int DEF_TIMEOUT_CYC = 1_000_000;
    localparam int BYTES_PER_WORD  = 4;

    // Frame length byte must name between 1 and depth words.
    function automatic logic len_valid(input logic [7:0] n, input int depth);
        return (n != 8'd0) && ({24'd0, n} <= depth);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs four sequential bytes into a little-endian 32-bit word.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane;
    logic [23:0] sr;

    // Earlier bytes shift down so byte 0 lands in bits [7:0] when the 4th arrives.
    assign word       = {byte_data, sr};
    assign word_valid = byte_valid && (lane == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= '0;
            sr   <= '0;
        end else if (clear) begin
            lane <= '0;
            sr   <= '0;
        end else if (byte_valid) begin
            lane <= lane + 2'd1;
            sr   <= {byte_data, sr[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: length, 4*N payload bytes, XOR checksum.
// Writes words to the instruction memory and holds the CPU while loading.
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t          state, next;
    logic            busy, arm, tmo, last_word, byte_in, asm_clear;
    logic            word_valid;
    logic [31:0]     word;
    logic [ADDR_W:0] len;
    logic [7:0]      csum;
    logic [TW-1:0]   tcnt;

    assign busy      = (state == LEN) || (state == DATA) || (state == CSUM);
    assign tmo       = busy && !rx_valid && (tcnt == TW'(TIMEOUT_CYC - 1));
    assign byte_in   = (state == DATA) && rx_valid;
    assign last_word = (words_loaded + (ADDR_W+1)'(1)) == len;
    // Any abort out of a busy state must also drop a partially assembled word.
    assign asm_clear = arm || (busy && (next == ERR));

    assign cpu_hold = busy;
    assign done     = (state == DONE);
    assign error    = (state == ERR);

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .byte_valid (byte_in),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        arm  = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    next = LEN;
                    arm  = 1'b1;
                end
            end
            LEN: begin
                if (rx_valid) next = len_valid(rx_data, DEPTH) ? DATA : ERR;
                else if (tmo) next = ERR;
            end
            DATA: begin
                if (word_valid && last_word) next = CSUM;
                else if (tmo)                next = ERR;
            end
            CSUM: begin
                if (rx_valid) next = (rx_data == csum) ? DONE : ERR;
                else if (tmo) next = ERR;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            len          <= '0;
            csum         <= '0;
            tcnt         <= '0;
        end else begin
            mem_we <= word_valid;
            if (word_valid) begin
                mem_addr     <= words_loaded[ADDR_W-1:0];
                mem_wdata    <= word;
                words_loaded <= words_loaded + (ADDR_W+1)'(1);
            end
            if (arm) begin
                words_loaded <= '0;
                csum         <= '0;
            end
            if (state == LEN && rx_valid) len <= (ADDR_W+1)'(rx_data);
            if (byte_in) csum <= csum ^ rx_data;
            if (!busy || rx_valid) tcnt <= '0;
            else                   tcnt <= tcnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by stimulus, checked by a monitor.
module tb_imem_loader;

    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int TMO    = 40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  wcyc[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_loader #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_e.a));
                chk("wr_data", mem_wdata, mon_e.d);
                wcyc.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) put(w[8*k +: 8]);
    endtask

    task automatic expect_wr(input int a, input logic [31:0] d);
        wr_t t;
        t.a = ADDR_W'(a);
        t.d = d;
        exp_q.push_back(t);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  x;

        // Reset state
        tick(2);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_hold", 32'(cpu_hold), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_words", 32'(words_loaded), 0);
        rst_n = 1'b1;
        tick(1);

        // 1: single word
        pulse_start;
        put(8'h01);
        chk("t1_hold", 32'(cpu_hold), 1);
        expect_wr(0, 32'h0000_0013);
        put_word(32'h0000_0013);
        put(8'h13);
        chk("t1_done", 32'(done), 1);
        chk("t1_error", 32'(error), 0);
        chk("t1_hold_low", 32'(cpu_hold), 0);
        chk("t1_words", 32'(words_loaded), 1);
        chk("t1_pending", 32'(exp_q.size()), 0);

        // 2: three words back to back, XOR of 11..CC is CC
        wcyc.delete();
        pulse_start;
        chk("t2_done_cleared", 32'(done), 0);
        chk("t2_words_cleared", 32'(words_loaded), 0);
        put(8'h03);
        expect_wr(0, 32'h4433_2211);
        expect_wr(1, 32'h8877_6655);
        expect_wr(2, 32'hCCBB_AA99);
        put_word(32'h4433_2211);
        put_word(32'h8877_6655);
        put_word(32'hCCBB_AA99);
        put(8'hCC);
        chk("t2_done", 32'(done), 1);
        chk("t2_hold_low", 32'(cpu_hold), 0);
        chk("t2_words", 32'(words_loaded), 3);
        chk("t2_pending", 32'(exp_q.size()), 0);
        chk("t2_nwrites", 32'(wcyc.size()), 3);
        chk("t2_gap01", (wcyc.size() >= 3) ? 32'(wcyc[1] - wcyc[0]) : 32'hFFFF_FFFF, 4);
        chk("t2_gap12", (wcyc.size() >= 3) ? 32'(wcyc[2] - wcyc[1]) : 32'hFFFF_FFFF, 4);

        // 3: bad checksum (true XOR 26, sent D9)
        pulse_start;
        put(8'h02);
        expect_wr(0, 32'hDEAD_BEEF);
        expect_wr(1, 32'h0102_0304);
        put_word(32'hDEAD_BEEF);
        put_word(32'h0102_0304);
        put(8'hD9);
        chk("t3_error", 32'(error), 1);
        chk("t3_done", 32'(done), 0);
        chk("t3_words", 32'(words_loaded), 2);
        chk("t3_pending", 32'(exp_q.size()), 0);

        // 4: zero and oversized lengths
        pulse_start;
        chk("t4_err_cleared", 32'(error), 0);
        put(8'h00);
        chk("t4_len0_error", 32'(error), 1);
        chk("t4_len0_hold", 32'(cpu_hold), 0);
        pulse_start;
        put(8'h81);
        chk("t4_len129_error", 32'(error), 1);
        chk("t4_words", 32'(words_loaded), 0);

        // 5: stall mid second word until timeout
        pulse_start;
        put(8'h02);
        expect_wr(0, 32'hA1B2_C3D4);
        put_word(32'hA1B2_C3D4);
        put(8'h55);
        put(8'h66);
        tick(TMO - 3);
        chk("t5_not_yet", 32'(error), 0);
        chk("t5_still_hold", 32'(cpu_hold), 1);
        tick(6);
        chk("t5_error", 32'(error), 1);
        chk("t5_hold_low", 32'(cpu_hold), 0);
        chk("t5_words", 32'(words_loaded), 1);
        chk("t5_pending", 32'(exp_q.size()), 0);
        // partial bytes must not leak into the next load (0D^F0^AD^0B = 5B)
        pulse_start;
        put(8'h01);
        expect_wr(0, 32'h0BAD_F00D);
        put_word(32'h0BAD_F00D);
        put(8'h5B);
        chk("t5_reload_done", 32'(done), 1);

        // 6: reset mid-DATA while a write strobe is up, then full-depth load
        pulse_start;
        put(8'h03);
        expect_wr(0, 32'h1111_2222);
        put_word(32'h1111_2222);
        tick(2);
        put_word(32'h3333_4444);
        chk("t6_we_before_rst", 32'(mem_we), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_we_async_drop", 32'(mem_we), 0);
        chk("t6_rst_hold", 32'(cpu_hold), 0);
        chk("t6_rst_words", 32'(words_loaded), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        put(8'h05);
        chk("t6_idle_ignores_rx", 32'(cpu_hold), 0);
        chk("t6_idle_no_error", 32'(error), 0);
        pulse_start;
        put(8'h80);
        x = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            w = {8'(i), 8'(~i), 8'(i ^ 8'h5A), 8'(i + 1)};
            for (int k = 0; k < 4; k++) x = x ^ w[8*k +: 8];
            expect_wr(i, w);
            put_word(w);
        end
        put(x);
        chk("t6_done", 32'(done), 1);
        chk("t6_error", 32'(error), 0);
        chk("t6_words", 32'(words_loaded), 128);
        chk("t6_last_addr", 32'(mem_addr), 127);
        chk("t6_pending", 32'(exp_q.size()), 0);

        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
